// File: rtl/bcd2bin_pkg.sv
// rtl/bcd2bin_pkg.sv - shared FSM encodings and default sizing for the BCD-to-binary converter
package bcd2bin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_DIGITS = 3;
  localparam int DEFAULT_BIN_W  = 10;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit_adjust.sv
// rtl/bcd_digit_adjust.sv - reverse double-dabble digit correction (subtract 3 when digit >= 8)
module bcd_digit_adjust (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= 4'd8) ? digit - 4'd3 : digit;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// rtl/bcd_to_binary_seq.sv - sequential BCD-to-binary converter, one reverse double-dabble bit per cycle
module bcd_to_binary_seq
  import bcd2bin_pkg::*;
#(
  parameter int DIGITS = DEFAULT_DIGITS,
  parameter int BIN_W  = DEFAULT_BIN_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      binary_out,
  output logic                  err
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  state_t              state;
  logic [WORK_W-1:0]   work;
  logic [WORK_W-1:0]   shifted;
  logic [WORK_W-1:0]   next_work;
  logic [CNT_W-1:0]    cnt;
  logic                bad_digit;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > DIGIT_MAX) bad_digit = 1'b1;
    end
  end

  // Corrections act on the already-shifted digits, all in parallel.
  assign shifted = work >> 1;
  assign next_work[BIN_W-1:0] = shifted[BIN_W-1:0];

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit    (shifted[BIN_W+4*i +: 4]),
      .adjusted (next_work[BIN_W+4*i +: 4])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      binary_out <= '0;
      err        <= 1'b0;
      work       <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (bad_digit) begin
              err        <= 1'b1;
              binary_out <= '0;
              out_valid  <= 1'b1;
              state      <= ST_DONE;
            end else begin
              work  <= {bcd_in, {BIN_W{1'b0}}};
              cnt   <= '0;
              err   <= 1'b0;
              state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          work <= next_work;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            binary_out <= next_work[BIN_W-1:0];
            out_valid  <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
